enc8to3_arbiter: RTL and testbench

- Sequential inverse of the 3-to-8 register-enable decoder: takes up to 8 one-hot-positioned request lines and produces a registered 3-bit grant index plus the matching one-hot grant vector.
- Round-robin fairness, a request/done handshake, and a hold timeout.
- Sits in front of the register-file/bus select logic, so a shared resource (bus, display, memory port) is owned by one requester at a time.
- Bit order matches the existing decoder: index 0 maps to vector bit 7, index 7 maps to bit 0.

---
 rtl/enc8to3_arbiter_pkg.sv | 15 +
 rtl/enc8to3_arbiter_if.sv | 12 +
 rtl/dec3to8.sv | 10 +
 rtl/enc8to3_arbiter_rr_pick8.sv | 25 ++
 rtl/enc8to3_arbiter.sv | 110 +++++++++++
 tb/tb_enc8to3_arbiter.sv | 152 +++++++++++++++
 6 files changed

// File: rtl/enc8to3_arbiter_pkg.sv
// Shared definitions for the 8-to-3 round-robin arbiter: state encoding and the
// index-to-one-hot table that follows the 3-to-8 decoder's bit order.
package enc8to3_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Index i selects vector bit (7-i), so index 0 maps to 8'h80.
  localparam logic [7:0][7:0] IDX2OH = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80
  };

endpackage

// File: rtl/enc8to3_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface enc8to3_arbiter_if;
  logic [7:0] req;
  logic       done;
  logic       valid;
  logic [2:0] grant;
  logic [7:0] grant_oh;
  logic       expired;

  modport master (output req, done, input valid, grant, grant_oh, expired);
  modport slave  (input req, done, output valid, grant, grant_oh, expired);
endinterface

// File: rtl/dec3to8.sv
// 3-to-8 register-enable decoder; output bit (7-a_i) is set when en_i is high.
module dec3to8
  import enc8to3_arbiter_pkg::*;
(
  input  logic       en_i,
  input  logic [2:0] a_i,
  output logic [7:0] y_o
);
  assign y_o = en_i ? IDX2OH[a_i] : 8'h00;
endmodule

// File: rtl/enc8to3_arbiter_rr_pick8.sv
// Rotate-and-priority-encode: first index i with req_i[7-i] set, searching from
// ptr_i upward with wrap from 7 to 0.
module rr_pick8 (
  input  logic [7:0] req_i,
  input  logic [2:0] ptr_i,
  output logic [2:0] index_o,
  output logic       any_o
);
  logic [2:0] cand;

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    index_o = ptr_i;
    any_o   = 1'b0;
    cand    = 3'd0;
    // Walk from the farthest candidate back to ptr_i so the nearest one wins.
    for (int k = 7; k >= 0; k--) begin
      cand = ptr_i + 3'(k);
      if (req_i[~cand]) begin
        index_o = cand;
        any_o   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/enc8to3_arbiter.sv
// Round-robin 8-requester arbiter with done/drop release and hold timeout;
// outputs a registered grant index, its one-hot form and an expiry pulse.
module enc8to3_arbiter
  import enc8to3_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  enc8to3_arbiter_if.slave    bus_io
);

  if (MAX_HOLD < 0 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("enc8to3_arbiter: MAX_HOLD must lie in 0..255");
  end

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  state_e     state_q, state_d;
  logic       valid_q, valid_d;
  logic [2:0] grant_q, grant_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic       expired_q, expired_d;
  logic [7:0] grant_oh_q, grant_oh_d;

  logic [2:0] pick_idx;
  logic       pick_any;
  logic       release_req;
  logic       timeout;

  rr_pick8 u_pick (
    .req_i   (bus_io.req),
    .ptr_i   (ptr_q),
    .index_o (pick_idx),
    .any_o   (pick_any)
  );

  // Owner i listens on req[7-i], and 7-i equals ~i for a 3-bit index.
  assign release_req = bus_io.done || !bus_io.req[~grant_q];
  assign timeout     = (MAX_HOLD_C != 8'd0) && (cnt_q == MAX_HOLD_C);

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    expired_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        if (pick_any) begin
          state_d = ST_GRANT;
          valid_d = 1'b1;
          grant_d = pick_idx;
          cnt_d   = 8'd1;
        end
      end
      ST_GRANT: begin
        if (release_req) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          ptr_d   = grant_q + 3'd1;
        end else if (timeout) begin
          state_d   = ST_IDLE;
          valid_d   = 1'b0;
          expired_d = 1'b1;
          ptr_d     = grant_q + 3'd1;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  dec3to8 u_dec (
    .en_i (valid_d),
    .a_i  (grant_d),
    .y_o  (grant_oh_d)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      valid_q    <= 1'b0;
      grant_q    <= 3'd0;
      ptr_q      <= 3'd0;
      cnt_q      <= 8'd0;
      expired_q  <= 1'b0;
      grant_oh_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      expired_q  <= expired_d;
      grant_oh_q <= grant_oh_d;
    end
  end

  assign bus_io.valid    = valid_q;
  assign bus_io.grant    = grant_q;
  assign bus_io.grant_oh = grant_oh_q;
  assign bus_io.expired  = expired_q;

endmodule

// File: tb/tb_enc8to3_arbiter.sv
// Directed plus randomized bench for enc8to3_arbiter against a cycle-level
// behavioural model of owner, pointer and hold time.
module tb_enc8to3_arbiter;

  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  enc8to3_arbiter_if bus ();

  enc8to3_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: owner is -1 while nobody holds the resource.
  int         m_owner   = -1;
  int         m_ptr     = 0;
  int         m_hold    = 0;
  int         m_grant   = 0;
  bit         m_expired = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_edge(input bit r, input logic [7:0] req, input bit done);
    if (r) begin
      m_owner = -1; m_ptr = 0; m_hold = 0; m_grant = 0; m_expired = 1'b0;
    end else if (m_owner < 0) begin
      m_expired = 1'b0;
      for (int k = 0; k < 8; k++) begin
        int idx;
        idx = (m_ptr + k) % 8;
        if (req[7 - idx]) begin
          m_owner = idx; m_grant = idx; m_hold = 1;
          break;
        end
      end
    end else begin
      m_expired = 1'b0;
      if (done || !req[7 - m_owner]) begin
        m_ptr = (m_owner + 1) % 8; m_owner = -1;
      end else if (MAX_HOLD != 0 && m_hold == MAX_HOLD) begin
        m_expired = 1'b1; m_ptr = (m_owner + 1) % 8; m_owner = -1;
      end else if (m_hold < 255) begin
        m_hold++;
      end
    end
  endtask

  // One clock: drive at negedge, advance the model at posedge, compare 1 ns later.
  task automatic cyc(input bit r, input logic [7:0] req, input bit done);
    logic [7:0] exp_oh;
    @(negedge clk);
    rst = r; bus.req = req; bus.done = done;
    @(posedge clk);
    model_edge(r, req, done);
    #1;
    exp_oh = (m_owner >= 0) ? (8'h80 >> m_grant) : 8'h00;
    check("valid",    32'(bus.valid),    32'(m_owner >= 0));
    check("grant",    32'(bus.grant),    32'(m_grant));
    check("grant_oh", 32'(bus.grant_oh), 32'(exp_oh));
    check("expired",  32'(bus.expired),  32'(m_expired));
  endtask

  // Cycle with hand-derived expectations on top of the model comparison.
  task automatic dcyc(input string tag, input bit r, input logic [7:0] req, input bit done,
                      input bit ev, input logic [7:0] eoh, input bit eexp);
    cyc(r, req, done);
    check({tag, ".valid"},    32'(bus.valid),    32'(ev));
    check({tag, ".grant_oh"}, 32'(bus.grant_oh), 32'(eoh));
    check({tag, ".expired"},  32'(bus.expired),  32'(eexp));
  endtask

  initial begin
    bus.req  = 8'h00;
    bus.done = 1'b0;

    // Reset held with all requests up, then first grant goes to index 0.
    dcyc("rst0", 1, 8'hFF, 0, 0, 8'h00, 0);
    dcyc("rst1", 1, 8'hFF, 0, 0, 8'h00, 0);
    dcyc("first", 0, 8'hFF, 0, 1, 8'h80, 0);
    dcyc("first_rel", 0, 8'hFF, 1, 0, 8'h00, 0);

    // Fairness between requesters 2 and 5.
    dcyc("fair_rst", 1, 8'h00, 0, 0, 8'h00, 0);
    dcyc("fair_g2",  0, 8'b00100100, 0, 1, 8'h20, 0);
    dcyc("fair_b1",  0, 8'b00100100, 1, 0, 8'h00, 0);
    dcyc("fair_g5",  0, 8'b00100100, 0, 1, 8'h04, 0);
    dcyc("fair_b2",  0, 8'b00100100, 1, 0, 8'h00, 0);
    dcyc("fair_g2b", 0, 8'b00100100, 0, 1, 8'h20, 0);
    check("fair_idx", 32'(bus.grant), 32'd2);

    // Wrap-around: grant/release 5 leaves ptr at 6, then 7 before 0.
    dcyc("wrap_rst", 1, 8'h00, 0, 0, 8'h00, 0);
    dcyc("wrap_g5",  0, 8'b00000100, 0, 1, 8'h04, 0);
    dcyc("wrap_r5",  0, 8'b00000100, 1, 0, 8'h00, 0);
    dcyc("wrap_g7",  0, 8'b10000001, 0, 1, 8'h01, 0);
    check("wrap_idx7", 32'(bus.grant), 32'd7);
    dcyc("wrap_b",   0, 8'b10000001, 1, 0, 8'h00, 0);
    dcyc("wrap_g0",  0, 8'b10000001, 0, 1, 8'h80, 0);
    check("wrap_idx0", 32'(bus.grant), 32'd0);

    // Timeout on requester 3: four valid cycles, one expiry cycle, regrant.
    dcyc("to_rst", 1, 8'h00, 0, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) dcyc("to_hold", 0, 8'b00010000, 0, 1, 8'h10, 0);
    dcyc("to_exp",   0, 8'b00010000, 0, 0, 8'h00, 1);
    dcyc("to_regnt", 0, 8'b00010000, 0, 1, 8'h10, 0);
    check("to_idx", 32'(bus.grant), 32'd3);

    // Done on the same edge as the timeout: plain release.
    dcyc("tod_rst", 1, 8'h00, 0, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) dcyc("tod_hold", 0, 8'b00010000, 0, 1, 8'h10, 0);
    dcyc("tod_rel", 0, 8'b00010000, 1, 0, 8'h00, 0);

    // Owner 1 drops its request; pointer moves to 2.
    dcyc("drop_rst", 1, 8'h00, 0, 0, 8'h00, 0);
    dcyc("drop_g1",  0, 8'h40, 0, 1, 8'h40, 0);
    dcyc("drop_h1",  0, 8'h40, 0, 1, 8'h40, 0);
    dcyc("drop_rel", 0, 8'h00, 0, 0, 8'h00, 0);
    dcyc("drop_ptr", 0, 8'hFF, 0, 1, 8'h20, 0);

    // Reset while 5 owns the grant; pointer returns to 0.
    dcyc("mid_rst0", 1, 8'h00, 0, 0, 8'h00, 0);
    dcyc("mid_g5",   0, 8'b00000100, 0, 1, 8'h04, 0);
    dcyc("mid_rst",  1, 8'b00000100, 0, 0, 8'h00, 0);
    dcyc("mid_g5b",  0, 8'b00000101, 0, 1, 8'h04, 0);
    check("mid_idx", 32'(bus.grant), 32'd5);

    // Randomized traffic: sparse requests, occasional done and reset.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] rq;
      rq = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom() & $urandom());
      cyc($urandom_range(0, 49) == 0, rq, $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
